msi_bus_arbiter: RTL and testbench

Snoop-bus controller for the two-core MSI system. It serializes bus transactions (read miss, write miss, invalidate) from the two private caches onto one shared snoop bus and the shared 512x16 memory read path. Each transaction runs in a fixed order: broadcast to the other cache, choose the data source (snooping cache or memory), then complete. It sits between the two cache controllers and the memory, replacing their direct point-to-point bus wiring.

---
 rtl/msi_bus_pkg.sv | 32 +++
 rtl/msi_bus_arbiter_chk.sv | 20 ++
 rtl/rr_arbiter2.sv | 53 +++++
 rtl/msi_bus_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_msi_bus_arbiter.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/msi_bus_pkg.sv
// Shared definitions for the two-core MSI snoop-bus controller:
// bus command encodings, FSM state type and default widths.
package msi_bus_pkg;

    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DATA_W = 16;

    localparam logic [1:0] CMD_NONE   = 2'b00;
    localparam logic [1:0] CMD_RDMISS = 2'b01;
    localparam logic [1:0] CMD_WRMISS = 2'b10;
    localparam logic [1:0] CMD_INV    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_SNOOP = 3'd2,
        ST_MEM   = 3'd3,
        ST_RESP  = 3'd4
    } bus_state_t;

    // Map a requester index onto its {port1, port0} strobe pair.
    function automatic logic [1:0] idx_to_onehot(input logic idx);
        logic [1:0] oh;
        if (idx) begin
            oh = 2'b10;
        end else begin
            oh = 2'b01;
        end
        return oh;
    endfunction

endpackage

// File: rtl/msi_bus_arbiter_chk.sv
// Protocol properties of the snoop-bus controller outputs: strobe pairs are
// mutually exclusive and the memory is never read and written together.
module msi_bus_arbiter_chk (
    input logic clk,
    input logic reset,
    input logic gnt0,
    input logic gnt1,
    input logic done0,
    input logic done1,
    input logic mem_rd,
    input logic mem_wr,
    input logic busy
);

    gnt_excl_a:  assert property (@(posedge clk) disable iff (reset) !(gnt0 && gnt1));
    done_excl_a: assert property (@(posedge clk) disable iff (reset) !(done0 && done1));
    mem_excl_a:  assert property (@(posedge clk) disable iff (reset) !(mem_rd && mem_wr));
    gnt_busy_a:  assert property (@(posedge clk) disable iff (reset) (gnt0 || gnt1) |-> busy);

endmodule

// File: rtl/rr_arbiter2.sv
// Two-input round-robin picker. The pointer remembers the last served
// requester; a mask removes requesters that must sit out this cycle.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_vld,
    input  logic [1:0] mask,
    input  logic       upd,
    input  logic       upd_idx,
    output logic       pick_vld,
    output logic       pick_idx
);

    logic       last_r;
    logic [1:0] elig_s;

    // Last-served pointer; starts at 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_r <= 1'b1;
        end else if (upd) begin
            last_r <= upd_idx;
        end else begin
            last_r <= last_r;
        end
    end

    // Pick among the unmasked requesters, favouring the one not served last.
    always_comb begin
        elig_s   = req_vld & ~mask;
        pick_vld = 1'b0;
        pick_idx = 1'b0;
        case (elig_s)
            2'b01: begin
                pick_vld = 1'b1;
                pick_idx = 1'b0;
            end
            2'b10: begin
                pick_vld = 1'b1;
                pick_idx = 1'b1;
            end
            2'b11: begin
                pick_vld = 1'b1;
                pick_idx = ~last_r;
            end
            default: begin
                pick_vld = 1'b0;
                pick_idx = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/msi_bus_arbiter.sv
// Snoop-bus controller for the two-core MSI system: serializes cache bus
// transactions through grant, snoop broadcast, optional memory fill and response.
module msi_bus_arbiter
    import msi_bus_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int SNOOP_CYC = 1,
    parameter int MEM_LAT   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [1:0]        cmd0,
    input  logic [1:0]        cmd1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        snoop_cmd,
    output logic [ADDR_W-1:0] snoop_addr,
    output logic              snoop_tgt,
    input  logic              snoop_hit,
    input  logic [DATA_W-1:0] snoop_data,
    input  logic              snoop_wb,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy
);

    localparam int MAX_CYC = (SNOOP_CYC > MEM_LAT) ? SNOOP_CYC : MEM_LAT;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] SNOOP_LAST = CNT_W'(SNOOP_CYC - 1);
    localparam logic [CNT_W-1:0] MEM_LAST   = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    bus_state_t        state_r;
    logic              owner_r;
    logic [1:0]        cmd_r;
    logic [ADDR_W-1:0] addr_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [1:0]        mask_r;

    logic [1:0]        valid_s;
    logic              pick_vld_s;
    logic              pick_idx_s;
    logic              rr_upd_s;

    // Request qualification; the pointer advances while the response is out.
    always_comb begin
        valid_s[0] = req0 && (cmd0 != CMD_NONE);
        valid_s[1] = req1 && (cmd1 != CMD_NONE);
        rr_upd_s   = (state_r == ST_RESP);
    end

    rr_arbiter2 u_rr (
        .clk      (clk),
        .reset    (reset),
        .req_vld  (valid_s),
        .mask     (mask_r),
        .upd      (rr_upd_s),
        .upd_idx  (owner_r),
        .pick_vld (pick_vld_s),
        .pick_idx (pick_idx_s)
    );

    // Transaction sequencer with all bus, memory and handshake outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            owner_r    <= 1'b0;
            cmd_r      <= CMD_NONE;
            addr_r     <= {ADDR_W{1'b0}};
            cnt_r      <= CNT_ZERO;
            mask_r     <= 2'b00;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            rdata      <= {DATA_W{1'b0}};
            snoop_cmd  <= CMD_NONE;
            snoop_addr <= {ADDR_W{1'b0}};
            snoop_tgt  <= 1'b0;
            mem_rd     <= 1'b0;
            mem_addr   <= {ADDR_W{1'b0}};
            mem_wr     <= 1'b0;
            mem_wdata  <= {DATA_W{1'b0}};
            busy       <= 1'b0;
        end else begin
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            done0  <= 1'b0;
            done1  <= 1'b0;
            mem_wr <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // The mask only covers the first idle cycle after a response.
                    mask_r <= 2'b00;
                    if (pick_vld_s) begin
                        owner_r      <= pick_idx_s;
                        cmd_r        <= pick_idx_s ? cmd1 : cmd0;
                        addr_r       <= pick_idx_s ? addr1 : addr0;
                        {gnt1, gnt0} <= idx_to_onehot(pick_idx_s);
                        busy         <= 1'b1;
                        state_r      <= ST_GRANT;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    snoop_cmd  <= cmd_r;
                    snoop_addr <= addr_r;
                    snoop_tgt  <= ~owner_r;
                    cnt_r      <= CNT_ZERO;
                    state_r    <= ST_SNOOP;
                end
                ST_SNOOP: begin
                    if (cnt_r == SNOOP_LAST) begin
                        snoop_cmd  <= CMD_NONE;
                        snoop_addr <= {ADDR_W{1'b0}};
                        snoop_tgt  <= 1'b0;
                        cnt_r      <= CNT_ZERO;
                        if (cmd_r == CMD_INV) begin
                            {done1, done0} <= idx_to_onehot(owner_r);
                            state_r        <= ST_RESP;
                        end else if (snoop_hit || snoop_wb) begin
                            // A write-back request alone still means the snooper owns the line.
                            rdata          <= snoop_data;
                            {done1, done0} <= idx_to_onehot(owner_r);
                            if (snoop_wb) begin
                                mem_wr    <= 1'b1;
                                mem_addr  <= addr_r;
                                mem_wdata <= snoop_data;
                            end else begin
                                mem_wr    <= 1'b0;
                                mem_addr  <= {ADDR_W{1'b0}};
                                mem_wdata <= mem_wdata;
                            end
                            state_r <= ST_RESP;
                        end else begin
                            mem_rd   <= 1'b1;
                            mem_addr <= addr_r;
                            state_r  <= ST_MEM;
                        end
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                        state_r <= ST_SNOOP;
                    end
                end
                ST_MEM: begin
                    if (cnt_r == MEM_LAST) begin
                        rdata          <= mem_rdata;
                        mem_rd         <= 1'b0;
                        mem_addr       <= {ADDR_W{1'b0}};
                        cnt_r          <= CNT_ZERO;
                        {done1, done0} <= idx_to_onehot(owner_r);
                        state_r        <= ST_RESP;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                        state_r <= ST_MEM;
                    end
                end
                ST_RESP: begin
                    // The served cache still holds req for one cycle after seeing done.
                    mask_r   <= idx_to_onehot(owner_r);
                    mem_addr <= {ADDR_W{1'b0}};
                    busy     <= 1'b0;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    mem_rd    <= 1'b0;
                    snoop_cmd <= CMD_NONE;
                    busy      <= 1'b0;
                    mask_r    <= 2'b00;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    msi_bus_arbiter_chk u_chk (
        .clk    (clk),
        .reset  (reset),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .done0  (done0),
        .done1  (done1),
        .mem_rd (mem_rd),
        .mem_wr (mem_wr),
        .busy   (busy)
    );

endmodule

// File: tb/tb_msi_bus_arbiter.sv
// Directed bench for msi_bus_arbiter: default-latency instance plus a
// SNOOP_CYC=3 / MEM_LAT=4 instance, checked with immediate assertions.
module tb_msi_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        req0, req1;
    logic [1:0]  cmd0, cmd1;
    logic [8:0]  addr0, addr1;
    logic        gnt0, gnt1, done0, done1;
    logic [15:0] rdata;
    logic [1:0]  snoop_cmd;
    logic [8:0]  snoop_addr;
    logic        snoop_tgt;
    logic        snoop_hit, snoop_wb;
    logic [15:0] snoop_data;
    logic        mem_rd, mem_wr;
    logic [8:0]  mem_addr;
    logic [15:0] mem_rdata, mem_wdata;
    logic        busy;

    logic        b_req0;
    logic [1:0]  b_cmd0;
    logic [8:0]  b_addr0;
    logic [15:0] b_mem_rdata;
    logic        b_gnt0, b_gnt1, b_done0, b_done1;
    logic [15:0] b_rdata;
    logic [1:0]  b_snoop_cmd;
    logic [8:0]  b_snoop_addr;
    logic        b_snoop_tgt;
    logic        b_mem_rd, b_mem_wr;
    logic [8:0]  b_mem_addr;
    logic [15:0] b_mem_wdata;
    logic        b_busy;

    int n_cmp = 0;
    int n_err = 0;

    msi_bus_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .cmd0(cmd0), .cmd1(cmd1),
        .addr0(addr0), .addr1(addr1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .snoop_cmd(snoop_cmd), .snoop_addr(snoop_addr),
        .snoop_tgt(snoop_tgt), .snoop_hit(snoop_hit), .snoop_data(snoop_data),
        .snoop_wb(snoop_wb), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .busy(busy)
    );

    msi_bus_arbiter #(.SNOOP_CYC(3), .MEM_LAT(4)) dut_slow (
        .clk(clk), .reset(reset),
        .req0(b_req0), .req1(1'b0), .cmd0(b_cmd0), .cmd1(2'b00),
        .addr0(b_addr0), .addr1(9'h000),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .done0(b_done0), .done1(b_done1),
        .rdata(b_rdata), .snoop_cmd(b_snoop_cmd), .snoop_addr(b_snoop_addr),
        .snoop_tgt(b_snoop_tgt), .snoop_hit(1'b0), .snoop_data(16'h0000),
        .snoop_wb(1'b0), .mem_rd(b_mem_rd), .mem_addr(b_mem_addr),
        .mem_rdata(b_mem_rdata), .mem_wr(b_mem_wr), .mem_wdata(b_mem_wdata), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; cmd0 = 2'b00; cmd1 = 2'b00;
        addr0 = 9'h000; addr1 = 9'h000;
        snoop_hit = 1'b0; snoop_wb = 1'b0; snoop_data = 16'h0000; mem_rdata = 16'h0000;
        b_req0 = 1'b0; b_cmd0 = 2'b00; b_addr0 = 9'h000; b_mem_rdata = 16'h0000;
        tick(); tick();
        chk("rst_strobes", {28'd0, gnt0, gnt1, done0, done1}, 32'h0);
        chk("rst_rdata", {16'd0, rdata}, 32'h0);
        chk("rst_mem", {30'd0, mem_rd, mem_wr}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        chk("rst_snoop", {30'd0, snoop_cmd}, 32'h0);
        reset = 1'b0;
        tick();

        // Memory fill from cache 0
        req0 = 1'b1; cmd0 = 2'b01; addr0 = 9'h012; mem_rdata = 16'hBEEF;
        tick();
        chk("fill_gnt0", {30'd0, gnt0, gnt1}, 32'h2);
        chk("fill_busy", {31'd0, busy}, 32'h1);
        tick();
        chk("fill_snoop_cmd", {30'd0, snoop_cmd}, 32'h1);
        chk("fill_snoop_tgt", {31'd0, snoop_tgt}, 32'h1);
        chk("fill_snoop_addr", {23'd0, snoop_addr}, 32'h012);
        tick();
        chk("fill_mem_rd", {31'd0, mem_rd}, 32'h1);
        chk("fill_mem_addr", {23'd0, mem_addr}, 32'h012);
        chk("fill_no_done_c3", {31'd0, done0}, 32'h0);
        tick();
        chk("fill_done0", {30'd0, done0, done1}, 32'h2);
        chk("fill_rdata", {16'd0, rdata}, 32'hBEEF);
        chk("fill_mem_rd_off", {31'd0, mem_rd}, 32'h0);
        req0 = 1'b0; cmd0 = 2'b00;
        tick();
        chk("fill_idle_busy", {31'd0, busy}, 32'h0);

        // Snoop hit with write-back, cache 1
        req1 = 1'b1; cmd1 = 2'b10; addr1 = 9'h1F0;
        tick();
        chk("hit_gnt1", {30'd0, gnt0, gnt1}, 32'h1);
        tick();
        chk("hit_snoop_cmd", {30'd0, snoop_cmd}, 32'h2);
        chk("hit_snoop_tgt", {31'd0, snoop_tgt}, 32'h0);
        snoop_hit = 1'b1; snoop_wb = 1'b1; snoop_data = 16'h1234;
        tick();
        chk("hit_mem_wr", {31'd0, mem_wr}, 32'h1);
        chk("hit_mem_addr", {23'd0, mem_addr}, 32'h1F0);
        chk("hit_mem_wdata", {16'd0, mem_wdata}, 32'h1234);
        chk("hit_no_mem_rd", {31'd0, mem_rd}, 32'h0);
        chk("hit_done1", {30'd0, done0, done1}, 32'h1);
        chk("hit_rdata", {16'd0, rdata}, 32'h1234);
        snoop_hit = 1'b0; snoop_wb = 1'b0; req1 = 1'b0; cmd1 = 2'b00;
        tick();
        chk("hit_wr_pulse_end", {31'd0, mem_wr}, 32'h0);

        // Invalidate from cache 0; a snoop hit must not touch rdata
        req0 = 1'b1; cmd0 = 2'b11; addr0 = 9'h055;
        tick();
        chk("inv_gnt0", {30'd0, gnt0, gnt1}, 32'h2);
        tick();
        chk("inv_snoop_cmd", {30'd0, snoop_cmd}, 32'h3);
        snoop_hit = 1'b1; snoop_data = 16'hAAAA;
        tick();
        chk("inv_done0", {30'd0, done0, done1}, 32'h2);
        chk("inv_rdata_kept", {16'd0, rdata}, 32'h1234);
        chk("inv_no_mem", {30'd0, mem_rd, mem_wr}, 32'h0);
        chk("inv_snoop_cmd_off", {30'd0, snoop_cmd}, 32'h0);
        snoop_hit = 1'b0; req0 = 1'b0; cmd0 = 2'b00;
        tick();

        // Write-back without hit from cache 1: memory bypassed, write-back kept
        req1 = 1'b1; cmd1 = 2'b01; addr1 = 9'h0AA;
        tick();
        chk("wb_gnt1", {30'd0, gnt0, gnt1}, 32'h1);
        tick();
        snoop_wb = 1'b1; snoop_data = 16'h5A5A;
        tick();
        chk("wb_done1", {30'd0, done0, done1}, 32'h1);
        chk("wb_mem_strobes", {30'd0, mem_rd, mem_wr}, 32'h1);
        chk("wb_rdata", {16'd0, rdata}, 32'h5A5A);
        snoop_wb = 1'b0; req1 = 1'b0; cmd1 = 2'b00;
        tick();

        // Both caches held with read misses: strict alternation 0,1,0,1
        req0 = 1'b1; cmd0 = 2'b01; addr0 = 9'h100;
        req1 = 1'b1; cmd1 = 2'b01; addr1 = 9'h101;
        mem_rdata = 16'h0F0F;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_gnt", {30'd0, gnt0, gnt1}, (k % 2 == 0) ? 32'h2 : 32'h1);
            tick(); tick(); tick();
            chk("rr_done", {30'd0, done0, done1}, (k % 2 == 0) ? 32'h2 : 32'h1);
            tick();
            chk("rr_idle_gap", {29'd0, gnt0, gnt1, busy}, 32'h0);
            if (k == 3) begin
                req0 = 1'b0; req1 = 1'b0; cmd0 = 2'b00; cmd1 = 2'b00;
            end
        end
        tick();

        // Single requester still holding req right after done is masked
        req0 = 1'b1; cmd0 = 2'b01; addr0 = 9'h020;
        tick();
        chk("mask_gnt0", {30'd0, gnt0, gnt1}, 32'h2);
        tick(); tick(); tick();
        chk("mask_done0", {31'd0, done0}, 32'h1);
        tick();
        tick();
        chk("mask_no_regrant", {30'd0, gnt0, busy}, 32'h0);
        req0 = 1'b0; cmd0 = 2'b00;
        tick();
        chk("mask_still_idle", {30'd0, gnt0, busy}, 32'h0);

        // Reset during the memory phase
        req1 = 1'b1; cmd1 = 2'b01; addr1 = 9'h0C3; mem_rdata = 16'h7777;
        tick();
        chk("rst_mid_gnt1", {31'd0, gnt1}, 32'h1);
        tick(); tick();
        chk("rst_mid_mem_rd", {31'd0, mem_rd}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_async", {27'd0, mem_rd, busy, gnt1, done1, mem_wr}, 32'h0);
        chk("rst_mid_addr", {23'd0, mem_addr}, 32'h0);
        tick();
        reset = 1'b0;
        req0 = 1'b1; cmd0 = 2'b01; addr0 = 9'h0C4;
        tick();
        chk("rst_tie_gnt0", {30'd0, gnt0, gnt1}, 32'h2);
        tick(); tick(); tick();
        chk("rst_done0_only", {30'd0, done0, done1}, 32'h2);
        chk("rst_fill_rdata", {16'd0, rdata}, 32'h7777);
        req0 = 1'b0; req1 = 1'b0; cmd0 = 2'b00; cmd1 = 2'b00;
        tick();

        // Slow instance: cmd 00 never granted, then a full memory fill
        b_req0 = 1'b1; b_cmd0 = 2'b00; b_addr0 = 9'h003;
        tick(); tick(); tick();
        chk("slow_cmd_none", {30'd0, b_gnt0, b_busy}, 32'h0);
        b_cmd0 = 2'b01; b_mem_rdata = 16'hCAFE;
        tick();
        chk("slow_gnt0", {30'd0, b_gnt0, b_gnt1}, 32'h2);
        for (int c = 2; c <= 9; c++) begin
            tick();
            chk("slow_snoop", {30'd0, b_snoop_cmd}, (c >= 2 && c <= 4) ? 32'h1 : 32'h0);
            chk("slow_mem_rd", {31'd0, b_mem_rd}, (c >= 5 && c <= 8) ? 32'h1 : 32'h0);
            chk("slow_done", {31'd0, b_done0}, (c == 9) ? 32'h1 : 32'h0);
        end
        chk("slow_rdata", {16'd0, b_rdata}, 32'hCAFE);
        b_req0 = 1'b0; b_cmd0 = 2'b00;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
